// File: rtl/comb_seq_exerciser.sv
// rtl/comb_seq_exerciser.sv - stimulus sweep and response checker for the A/B/C/Q lab circuit
module comb_seq_exerciser #(
  parameter int PASSES = 1,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             dut_rst,
  output logic             A,
  output logic             B,
  output logic             C,
  input  logic             Q,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_fail_valid,
  output logic             first_fail_rst,
  output logic [2:0]       first_fail_vec
);

  localparam int N  = 8 * PASSES;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [2:0] {IDLE, DUT_RST, RST_CHK, DRIVE, DRAIN, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            exp_d;
  logic            chk_d;
  logic [2:0]      vec_d;
  logic [2:0]      abc;
  logic            chk_err;
  logic            rst_err;
  logic            any_err;
  logic [ERR_W-1:0] err_next;

  assign abc = {A, B, C};

  // Q lags the driven vector by two edges; vec_d/exp_d carry the vector along.
  assign chk_err  = chk_d && (Q != exp_d);
  assign rst_err  = (state == RST_CHK) && Q;
  assign any_err  = chk_err || rst_err;
  assign err_next = (any_err && (err_count != '1)) ? err_count + 1'b1 : err_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      exp_d            <= 1'b0;
      chk_d            <= 1'b0;
      vec_d            <= 3'b000;
      dut_rst          <= 1'b0;
      A                <= 1'b0;
      B                <= 1'b0;
      C                <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_rst   <= 1'b0;
      first_fail_vec   <= 3'b000;
    end else begin
      exp_d <= |abc;
      vec_d <= abc;
      chk_d <= (state == DRIVE);

      if (any_err) begin
        err_count <= err_next;
        if (!first_fail_valid) begin
          first_fail_valid <= 1'b1;
          first_fail_rst   <= rst_err;
          first_fail_vec   <= rst_err ? 3'b000 : vec_d;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            busy             <= 1'b1;
            dut_rst          <= 1'b1;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_rst   <= 1'b0;
            first_fail_vec   <= 3'b000;
            state            <= DUT_RST;
          end
        end
        DUT_RST: begin
          dut_rst <= 1'b0;
          state   <= RST_CHK;
        end
        RST_CHK: begin
          {A, B, C} <= 3'b000;
          cnt       <= CW'(1);
          state     <= DRIVE;
        end
        DRIVE: begin
          if (cnt == CW'(N)) begin
            {A, B, C} <= 3'b000;
            state     <= DRAIN;
          end else begin
            {A, B, C} <= cnt[2:0];
            cnt       <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (err_next == '0);
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comb_seq_exerciser.sv
// tb/tb_comb_seq_exerciser.sv - randomized bench for comb_seq_exerciser against an edge-count model
module tb_comb_seq_exerciser;

  localparam int PASSES = 2;
  localparam int ERR_W  = 3;
  localparam int N      = 8 * PASSES;
  localparam int SAT    = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             dut_rst, A, B, C, Q, busy, done, pass;
  logic [ERR_W-1:0] err_count;
  logic             first_fail_valid, first_fail_rst;
  logic [2:0]       first_fail_vec;

  always #5 clk = ~clk;

  comb_seq_exerciser #(.PASSES(PASSES), .ERR_W(ERR_W)) u_dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .dut_rst          (dut_rst),
    .A                (A),
    .B                (B),
    .C                (C),
    .Q                (Q),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .err_count        (err_count),
    .first_fail_valid (first_fail_valid),
    .first_fail_rst   (first_fail_rst),
    .first_fail_vec   (first_fail_vec)
  );

  // Circuit under test: 0 correct, 1 stuck-at-0, 2 stuck-at-1 (ignores reset), 3 random.
  int   mode = 0;
  logic q_reg = 1'b0;
  assign Q = q_reg;
  always @(posedge clk) begin
    case (mode)
      0:       q_reg <= dut_rst ? 1'b0 : (C | (A & B) | (A ^ B));
      1:       q_reg <= 1'b0;
      2:       q_reg <= 1'b1;
      default: q_reg <= 1'($urandom);
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: m_e counts edges since start acceptance (-1 when idle).
  int       m_e = -1;
  int       m_err = 0;
  logic     m_pass = 1'b0, m_ffv = 1'b0, m_ffr = 1'b0;
  logic [2:0] m_ffvec = 3'b000;

  function automatic void m_fail(input logic r, input logic [2:0] v);
    if (m_err < SAT) m_err++;
    if (!m_ffv) begin
      m_ffv = 1'b1;
      m_ffr = r;
      m_ffvec = v;
    end
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_e = -1; m_err = 0; m_pass = 0; m_ffv = 0; m_ffr = 0; m_ffvec = 0;
    end else begin
      if (m_e < 0) begin
        if (start) begin
          m_e = 0; m_err = 0; m_pass = 0; m_ffv = 0; m_ffr = 0; m_ffvec = 0;
        end
      end else if (m_e == N + 3) m_e = -1;
      else m_e++;
      if (m_e == 2 && Q) m_fail(1'b1, 3'b000);
      if (m_e >= 4 && m_e <= N + 3 && (Q != (((m_e - 4) % 8) != 0)))
        m_fail(1'b0, 3'((m_e - 4) % 8));
      if (m_e == N + 3) m_pass = (m_err == 0);
    end
  end

  int passed = 0;
  int total  = 0;
  bit chk_en = 0;

  task automatic check(input string nm, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s actual=%0d required=%0d", nm, act, req);
  endtask

  function automatic logic [31:0] act_vec();
    return 32'({dut_rst, A, B, C, busy, done, pass, first_fail_valid,
                first_fail_rst, first_fail_vec, err_count});
  endfunction

  task automatic tick();
    logic [2:0]  e_abc;
    logic [31:0] req;
    @(negedge clk);
    if (chk_en) begin
      e_abc = (m_e >= 2 && m_e <= N + 1) ? 3'((m_e - 2) % 8) : 3'b000;
      req = 32'({(m_e == 0), e_abc, (m_e >= 0 && m_e <= N + 2), (m_e == N + 3),
                 m_pass, m_ffv, m_ffr, m_ffvec, ERR_W'(m_err)});
      total++;
      if (act_vec() == req) passed++;
      else $display("FAIL outputs t=%0t actual=%h required=%h", $time, act_vec(), req);
    end
  endtask

  task automatic run(input int md, output int lat);
    int t0;
    mode = md;
    start = 1'b1;
    t0 = cyc + 1;
    tick();
    start = 1'b0;
    lat = -1;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (done) begin
        lat = cyc - t0;
        break;
      end
    end
    tick();
  endtask

  int lat;
  int dones;

  initial begin
    @(posedge clk);
    chk_en = 1;
    tick(); tick();
    check("reset_outputs", int'(act_vec()), 0);
    reset = 1'b0;
    tick();

    run(0, lat);
    check("good_latency", lat, N + 3);
    check("good_pass", pass, 1);
    check("good_err", err_count, 0);
    check("good_ffv", first_fail_valid, 0);

    run(1, lat);
    check("stuck0_err_sat", err_count, SAT);
    check("stuck0_ffv", first_fail_valid, 1);
    check("stuck0_ffr", first_fail_rst, 0);
    check("stuck0_ffvec", first_fail_vec, 1);
    check("stuck0_pass", pass, 0);

    run(2, lat);
    check("stuck1_err", err_count, 3);
    check("stuck1_ffr", first_fail_rst, 1);
    check("stuck1_ffvec", first_fail_vec, 0);
    check("stuck1_pass", pass, 0);

    // Extra starts during busy and in DONE must be ignored.
    mode = 0;
    start = 1'b1;
    tick();
    dones = 0;
    for (int k = 1; k <= 24; k++) begin
      start = (k == 5 || k == 11 || k == N + 4);
      tick();
      if (done) dones++;
    end
    start = 1'b0;
    check("ignored_starts_dones", dones, 1);
    check("ignored_starts_busy", busy, 0);
    check("ignored_starts_pass", pass, 1);

    // Reset mid-sweep.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 5; k++) tick();
    reset = 1'b1;
    tick();
    check("midrun_reset_outputs", int'(act_vec()), 0);
    reset = 1'b0;
    run(0, lat);
    check("after_reset_pass", pass, 1);
    check("after_reset_latency", lat, N + 3);

    // start held high restarts each time IDLE is reached.
    start = 1'b1;
    dones = 0;
    for (int k = 0; k < 45; k++) begin
      tick();
      if (done) dones++;
    end
    start = 1'b0;
    check("held_start_dones", dones, 2);
    for (int k = 0; k < 30; k++) tick();

    for (int k = 0; k < 1500; k++) begin
      if (k % 40 == 0) mode = $urandom_range(0, 3);
      start = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 99) == 0);
      tick();
    end
    start = 1'b0;
    reset = 1'b0;
    for (int k = 0; k < 30; k++) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
